// File: rtl/powlib_unpack.sv
// Width down-converter: one R*W-bit word in, R W-bit beats out, LS beat first.
// Optional rdlast output enabled by defining POWLIB_UNPACK_LAST_EN.
module powlib_unpack #(
    parameter int W    = 8,
    parameter int R    = 4,
    parameter int EDBG = 0,
    parameter     ID   = "UNPACK"
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W*R-1:0] wrdata,
    input  logic           wrvld,
    output logic           wrrdy,
    output logic [W-1:0]   rddata,
    output logic           rdvld,
    input  logic           rdrdy
`ifdef POWLIB_UNPACK_LAST_EN
    ,
    output logic           rdlast
`endif
);

    localparam int             CW    = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0]  CNT_L = CW'(R - 1);

    if (R < 2 || W < 1) begin : g_bad_cfg
        $fatal(1, "%s: illegal configuration R=%0d W=%0d (need R>=2, W>=1)", ID, R, W);
    end

    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W*R-1:0] hold_q, hold_d;
    logic           last;
    logic           wrinc;
    logic           rdinc;

    assign wrinc = wrvld && wrrdy;
    assign rdinc = rdvld && rdrdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hold_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    // The last beat and a new word may complete together: reload without a bubble.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        if (!busy_q) begin
            if (wrinc) begin
                hold_d = wrdata;
                cnt_d  = '0;
                busy_d = 1'b1;
            end
        end else if (rdinc) begin
            if (cnt_q == CNT_L) begin
                cnt_d = '0;
                if (wrinc) begin
                    hold_d = wrdata;
                end else begin
                    busy_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Explicit beat mux so indices >= R are never selected for non-power-of-2 R.
    always_comb begin
        rdvld  = busy_q && !rst;
        last   = busy_q && !rst && (cnt_q == CNT_L);
        wrrdy  = !rst && (!busy_q || (last && rdrdy));
        rddata = '0;
        for (int i = 0; i < R; i++) begin
            if (cnt_q == CW'(i)) begin
                rddata = hold_q[i*W +: W];
            end
        end
        if (rst) begin
            rddata = '0;
        end
    end

`ifdef POWLIB_UNPACK_LAST_EN
    assign rdlast = last;
`endif

    if (EDBG != 0) begin : g_dbg
        always_ff @(posedge clk) begin
            if (!rst && wrinc) begin
                $display("%s: accept word %h", ID, wrdata);
            end
            if (!rst && rdinc) begin
`ifdef POWLIB_UNPACK_LAST_EN
                $display("%s: beat %0d data %h rdlast %b", ID, cnt_q, rddata, last);
`else
                $display("%s: beat %0d data %h", ID, cnt_q, rddata);
`endif
            end
        end
    end

endmodule
